// File: rtl/ste_arb_pkg.sv
// Shared widths and the pipeline tag type for the short-time-energy arbiter.
package ste_arb_pkg;
  localparam int DATA_WIDTH = 16;
  localparam int SUM_WIDTH  = 31;
  localparam int SQ_ADDR_W  = 7;
  localparam int SQ_WIDTH   = 15;
  localparam int TAG_CH_W   = 4;

  typedef struct packed {
    logic                valid;
    logic [TAG_CH_W-1:0] ch;
  } pipe_tag_t;
endpackage

// File: rtl/square_lut.sv
// Registered 7-bit squarer shared by all channels; one-cycle latency, clock enable.
module square_lut
  import ste_arb_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en_i,
  input  logic [SQ_ADDR_W-1:0] addr_i,
  output logic [SQ_WIDTH-1:0]  q_o
);
  logic [SQ_WIDTH-1:0] a_ext;
  logic [SQ_WIDTH-1:0] sq_q;

  assign a_ext = SQ_WIDTH'(addr_i);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     sq_q <= '0;
    else if (en_i) sq_q <= a_ext * a_ext;
  end

  assign q_o = sq_q;
endmodule

// File: rtl/ste_arbiter.sv
// Round-robin arbiter feeding a shared squares lookup into per-channel energy windows.
// Optional STE_THRESH_EN adds a per-channel activity flag on each completion.
module ste_arbiter #(
  parameter int DATA_WIDTH  = ste_arb_pkg::DATA_WIDTH,
  parameter int NUM_CH      = 4,
  parameter int WINDOW_SIZE = 64,
  parameter int SUM_WIDTH   = ste_arb_pkg::SUM_WIDTH,
  parameter int THRESHOLD   = 100000,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int CNT_W = (WINDOW_SIZE > 1) ? $clog2(WINDOW_SIZE) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_data,
  input  logic [NUM_CH-1:0]            ch_valid,
  output logic [NUM_CH-1:0]            ch_ready,
  output logic [SUM_WIDTH-1:0]         ste_out,
  output logic [CH_W-1:0]              ste_ch,
  output logic                         ste_valid,
  output logic [NUM_CH-1:0]            ste_active
);
  import ste_arb_pkg::*;

  // S0: grant and lookup address
  logic [CH_W-1:0]       ptr_q, ptr_d;
  logic [NUM_CH-1:0]     gnt;
  logic [CH_W-1:0]       gnt_idx;
  logic                  any_gnt;
  logic [DATA_WIDTH-1:0] smp, mag;
  logic [SQ_ADDR_W-1:0]  lut_addr;
  int                    idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    smp     = '0;
    idx     = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!any_gnt && ch_valid[idx]) begin
        any_gnt   = 1'b1;
        gnt[idx]  = 1'b1;
        gnt_idx   = CH_W'(idx);
        smp       = ch_data[idx*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    if (reset || clear) begin
      gnt     = '0;
      any_gnt = 1'b0;
    end
  end

  assign ch_ready = gnt;
  assign ptr_d    = !any_gnt ? ptr_q :
                    (gnt_idx == CH_W'(NUM_CH-1)) ? '0 : gnt_idx + 1'b1;

  // Most negative sample has no positive twin; pin it to the largest magnitude.
  assign mag = !smp[DATA_WIDTH-1] ? smp :
               (smp == {1'b1, {(DATA_WIDTH-1){1'b0}}}) ? {1'b0, {(DATA_WIDTH-1){1'b1}}} : -smp;
  assign lut_addr = mag[DATA_WIDTH-2 -: SQ_ADDR_W];

  logic unused_mag;
  assign unused_mag = ^{mag[DATA_WIDTH-1], mag[DATA_WIDTH-2-SQ_ADDR_W:0]};

  // S1: registered square (inside the LUT) plus channel tag
  logic [SQ_WIDTH-1:0] lut_q, sq2_q;
  pipe_tag_t           s1_q, s1_d, s2_q, s2_d;

  square_lut u_lut (
    .clk    (clk),
    .reset  (reset),
    .en_i   (any_gnt),
    .addr_i (lut_addr),
    .q_o    (lut_q)
  );

  assign s1_d = '{valid: any_gnt, ch: TAG_CH_W'(gnt_idx)};
  assign s2_d = '{valid: s1_q.valid && !clear, ch: s1_q.ch};

  // S2: accumulate; the window's last sample reports and restarts the channel
  logic [NUM_CH-1:0][SUM_WIDTH-1:0] acc_q, acc_d;
  logic [NUM_CH-1:0][CNT_W-1:0]     cnt_q, cnt_d;
  logic [SUM_WIDTH-1:0]             sel_acc, sum_sat;
  logic [SUM_WIDTH:0]               sum_w;
  logic [CNT_W-1:0]                 sel_cnt;
  logic                             fire, last;

  always_comb begin
    sel_acc = '0;
    sel_cnt = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (s2_q.ch == TAG_CH_W'(c)) begin
        sel_acc = acc_q[c];
        sel_cnt = cnt_q[c];
      end
    end
    sum_w   = {1'b0, sel_acc} + (SUM_WIDTH+1)'(sq2_q);
    sum_sat = sum_w[SUM_WIDTH] ? '1 : sum_w[SUM_WIDTH-1:0];
    last    = (sel_cnt == CNT_W'(WINDOW_SIZE-1));
    fire    = s2_q.valid && !clear;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    for (int c = 0; c < NUM_CH; c++) begin
      if (clear) begin
        acc_d[c] = '0;
        cnt_d[c] = '0;
      end else if (fire && s2_q.ch == TAG_CH_W'(c)) begin
        acc_d[c] = last ? '0 : sum_sat;
        cnt_d[c] = last ? '0 : sel_cnt + 1'b1;
      end
    end
  end

  logic [SUM_WIDTH-1:0] ste_out_q;
  logic [CH_W-1:0]      ste_ch_q;
  logic                 ste_valid_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q       <= '0;
      s1_q        <= '0;
      s2_q        <= '0;
      sq2_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      ste_out_q   <= '0;
      ste_ch_q    <= '0;
      ste_valid_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      sq2_q       <= lut_q;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ste_valid_q <= fire && last;
      if (fire && last) begin
        ste_out_q <= sum_sat;
        ste_ch_q  <= CH_W'(s2_q.ch);
      end
    end
  end

  assign ste_out   = ste_out_q;
  assign ste_ch    = ste_ch_q;
  assign ste_valid = ste_valid_q;

`ifdef STE_THRESH_EN
  logic [NUM_CH-1:0] act_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     act_q <= '0;
    else if (clear) act_q <= '0;
    else if (fire && last) begin
      for (int c = 0; c < NUM_CH; c++)
        if (s2_q.ch == TAG_CH_W'(c)) act_q[c] <= (sum_sat > SUM_WIDTH'(THRESHOLD));
    end
  end

  assign ste_active = act_q;
`else
  logic [31:0] unused_thresh;
  assign unused_thresh = THRESHOLD;
  assign ste_active    = '0;
`endif
endmodule

// File: tb/tb_ste_arbiter.sv
// Directed scoreboard bench for ste_arbiter: driver pushes expected completions, monitor pops on ste_valid.
module tb_ste_arbiter;
  localparam int WIN = 64;
`ifdef STE_THRESH_EN
  localparam bit THR = 1'b1;
`else
  localparam bit THR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, clear;
  logic [63:0] ch_data;
  logic [3:0]  ch_valid, ch_ready, ste_active;
  logic [30:0] ste_out;
  logic [1:0]  ste_ch;
  logic        ste_valid;

  ste_arbiter dut (
    .clk(clk), .reset(reset), .clear(clear), .ch_data(ch_data), .ch_valid(ch_valid),
    .ch_ready(ch_ready), .ste_out(ste_out), .ste_ch(ste_ch), .ste_valid(ste_valid),
    .ste_active(ste_active)
  );

  always #5 clk = ~clk;

  typedef struct { int ch; longint out; int cyc; } exp_t;
  exp_t   sb[$];
  int     n_chk = 0, n_fail = 0, cyc = 0;
  int     rr, cnt [4];
  longint exp_e [4];
  bit     drop;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every completion must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!reset && ste_valid) begin
      if (sb.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_ste_valid: got ch %0d out %0d, expected none", ste_ch, ste_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ste_ch", 64'(ste_ch), 64'(e.ch));
        chk("ste_out", 64'(ste_out), 64'(e.out));
        chk("ste_latency", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // One cycle of stimulus; called just after a rising edge
  task automatic step(input logic [3:0] v, input logic [63:0] d);
    logic [3:0] eg;
    int gc;
    exp_t e;
    ch_valid = v;
    ch_data  = d;
    @(negedge clk);
    eg = '0;
    gc = -1;
    if (!clear) begin
      for (int i = 0; i < 4; i++) begin
        int c;
        c = (rr + i) % 4;
        if (gc < 0 && v[c]) begin
          gc    = c;
          eg[c] = 1'b1;
        end
      end
    end
    chk("ch_ready", 64'(ch_ready), 64'(eg));
    if (clear) begin
      for (int i = 0; i < 4; i++) cnt[i] = 0;
    end else if (gc >= 0) begin
      rr = (gc + 1) % 4;
      cnt[gc]++;
      if (cnt[gc] == WIN) begin
        cnt[gc] = 0;
        if (!drop) begin
          e.ch = gc; e.out = exp_e[gc]; e.cyc = cyc + 3;
          sb.push_back(e);
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic run(input int ch, input logic [15:0] s, input int n);
    for (int k = 0; k < n; k++) step(4'b0001 << ch, {4{s}});
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(4'b0000, 64'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"},  64'(ch_ready), 64'd0);
    chk({tag, "_valid"},  64'(ste_valid), 64'd0);
    chk({tag, "_out"},    64'(ste_out), 64'd0);
    chk({tag, "_ch"},     64'(ste_ch), 64'd0);
    chk({tag, "_active"}, 64'(ste_active), 64'd0);
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; ch_valid = 4'hF; ch_data = '0;
    rr = 0; drop = 1'b0;
    for (int i = 0; i < 4; i++) begin cnt[i] = 0; exp_e[i] = 0; end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("por");
    @(posedge clk); #1;
    reset = 1'b0; ch_valid = '0;

    // ch0 full-scale window: 64 * 127^2
    exp_e[0] = 1032256;
    run(0, 16'h7F00, 64);
    idle(5);
    chk("hold_out", 64'(ste_out), 64'd1032256);
    chk("hold_ch", 64'(ste_ch), 64'd0);
    chk("active_hi", 64'(ste_active), THR ? 64'd1 : 64'd0);

    // small ch0 window drops activity again
    exp_e[0] = 64;
    run(0, 16'h0100, 64);
    idle(4);
    chk("active_lo", 64'(ste_active), 64'd0);

    // most negative sample saturates to the 127 bucket
    exp_e[1] = 1032256;
    run(1, 16'h8000, 64);
    idle(4);

    // all channels streaming: completions land on consecutive cycles
    exp_e[0] = 64; exp_e[1] = 256; exp_e[2] = 576; exp_e[3] = 576;
    repeat (256) step(4'hF, {16'hFD00, 16'h0300, 16'h0200, 16'h0100});
    idle(4);
    chk("active_mix", 64'(ste_active), 64'd0);

    // clear on ch2's final S2 cycle; also wipes a partial ch0 window
    exp_e[0] = 1032256;
    run(0, 16'h7F00, 10);
    exp_e[2] = 64;
    run(2, 16'h0100, 63);
    drop = 1'b1;
    run(2, 16'h0100, 1);
    drop = 1'b0;
    idle(1);
    clear = 1'b1;
    step(4'b0101, {4{16'h0100}});
    clear = 1'b0;
    idle(4);
    exp_e[0] = 64;
    run(0, 16'h0100, 64);
    run(2, 16'h0100, 64);
    idle(4);

    // reset mid-window on ch3
    exp_e[3] = 64;
    run(3, 16'h7F00, 30);
    reset = 1'b1; ch_valid = 4'hF;
    @(negedge clk);
    chk_reset_outputs("mid");
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    rr = 0;
    @(posedge clk); #1;
    reset = 1'b0; ch_valid = '0;
    run(3, 16'h0100, 64);
    idle(5);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
